// File: rtl/core_pkg.sv
// Shared types and constants for the instruction sequencer.
package core_pkg;

  localparam int NUM_STAGES = 5;

  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_EXEC   = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  // One-hot stage mask for a state; zero for the non-stage states.
  function automatic logic [NUM_STAGES-1:0] stage_mask(input state_e s);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    case (s)
      ST_FETCH:  m[STG_FETCH]  = 1'b1;
      ST_DECODE: m[STG_DECODE] = 1'b1;
      ST_EXEC:   m[STG_EXEC]   = 1'b1;
      ST_MEM:    m[STG_MEM]    = 1'b1;
      ST_WB:     m[STG_WB]     = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage wait counter. Cleared on stage entry, counts waiting cycles and
// flags the waiting cycle on which the count reaches TIMEOUT.
module stage_watchdog #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt;

  // Wait counter: clear wins over run, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= 8'd0;
    else if (run && cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end

  // Fires on the waiting cycle whose increment makes the count equal TIMEOUT.
  // Widened compare so TIMEOUT=0 never fires rather than aliasing to 256.
  always_comb begin
    expired = run && (({1'b0, cnt} + 9'd1) == {1'b0, TIMEOUT});
  end

endmodule

// File: rtl/core_sequencer.sv
// Five-stage instruction sequencer: pulses one stage enable per stage entry,
// waits for the matching done, tracks PC and retired count, and traps to ERR
// when a stage stalls beyond TIMEOUT waiting cycles.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_en,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  input  logic                  skip_mem,
  input  logic                  halt_req,
  output logic [31:0]           pc,
  output logic [31:0]           retired,
  output logic                  busy,
  output logic                  halted,
  output logic                  err
);

  state_e                state, state_nxt;
  logic                  entry, entry_nxt;   // high on the first cycle of a stage state
  logic [NUM_STAGES-1:0] mask;
  logic                  in_stage, waiting, done_hit, wb_done, wd_expired;

  // Decode of the current stage and whether its done has been seen.
  always_comb begin
    mask     = stage_mask(state);
    in_stage = |mask;
    waiting  = in_stage && !entry;
    done_hit = waiting && |(stage_done & mask);
    wb_done  = done_hit && (state == ST_WB);
  end

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .run     (waiting),
    .expired (wd_expired)
  );

  // Next-state logic; a done on the timeout cycle takes priority over ERR.
  always_comb begin
    state_nxt = state;
    entry_nxt = 1'b0;
    if (state == ST_IDLE) begin
      if (start) begin
        state_nxt = ST_FETCH;
        entry_nxt = 1'b1;
      end
    end else if (in_stage) begin
      if (done_hit) begin
        entry_nxt = 1'b1;
        case (state)
          ST_FETCH:  state_nxt = ST_DECODE;
          ST_DECODE: state_nxt = ST_EXEC;
          ST_EXEC:   state_nxt = skip_mem ? ST_WB : ST_MEM;
          ST_MEM:    state_nxt = ST_WB;
          ST_WB: begin
            if (halt_req) begin
              state_nxt = ST_HALT;
              entry_nxt = 1'b0;
            end else begin
              state_nxt = ST_FETCH;
            end
          end
          default:   state_nxt = state;
        endcase
      end else if (wd_expired) begin
        state_nxt = ST_ERR;
      end
    end
  end

  // State, PC and retired registers; PC and retired only move at WB done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      entry   <= 1'b0;
      pc      <= RESET_PC;
      retired <= 32'd0;
    end else begin
      state <= state_nxt;
      entry <= entry_nxt;
      if (wb_done) begin
        if (retired != 32'hFFFF_FFFF)
          retired <= retired + 32'd1;
        pc <= branch_taken ? branch_target : pc + 32'd1;
      end
    end
  end

  // Status outputs are pure decodes of the state register.
  always_comb begin
    stage_en = entry ? mask : '0;
    busy     = in_stage;
    halted   = (state == ST_HALT);
    err      = (state == ST_ERR);
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer against a stage-level reference model.
module tb_core_sequencer;

  localparam logic [31:0] RPC = 32'hFFFF_FFFE;
  localparam int          TO  = 8;

  logic        clk = 1'b0;
  logic        rst, start, branch_taken, skip_mem, halt_req;
  logic [4:0]  stage_done, stage_en;
  logic [31:0] branch_target, pc, retired;
  logic        busy, halted, err;

  core_sequencer #(.RESET_PC(RPC), .TIMEOUT(8'(TO))) dut (
    .clk(clk), .rst(rst), .start(start), .stage_done(stage_done),
    .stage_en(stage_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .skip_mem(skip_mem),
    .halt_req(halt_req), .pc(pc), .retired(retired),
    .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 halted, 3 error.
  // m_age = 0 on the entry cycle of stage m_stg, k on the k-th waiting cycle.
  int          m_mode, m_stg, m_age, m_d;
  logic [31:0] m_pc, m_ret;
  int          maxd, p_to, p_skip, p_br, p_halt, p_rst, p_noise, stuck;

  function automatic int pick_delay(input int md, input int pto);
    if (int'($urandom_range(0, 99)) < pto) return TO + 4;
    return int'($urandom_range(1, md));
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'd4;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'hFFFF_FFFE;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] exp_en;
    rst = 1'b1; start = 1'b0; stage_done = '0; branch_taken = 1'b0;
    branch_target = '0; skip_mem = 1'b0; halt_req = 1'b0;
    m_mode = 0; m_stg = 0; m_age = 0; m_d = 1; m_pc = RPC; m_ret = 0; stuck = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // Phase knobs: clean back-to-back, skip, branches, timeouts, halts, all.
      case (cyc / 500)
        0:       begin maxd = 1; p_to = 0;  p_skip = 0;  p_br = 0;  p_halt = 0;  p_rst = 0;  p_noise = 0; end
        1:       begin maxd = 1; p_to = 0;  p_skip = 50; p_br = 0;  p_halt = 0;  p_rst = 0;  p_noise = 0; end
        2:       begin maxd = 4; p_to = 0;  p_skip = 30; p_br = 50; p_halt = 0;  p_rst = 0;  p_noise = 1; end
        3:       begin maxd = 6; p_to = 15; p_skip = 30; p_br = 30; p_halt = 0;  p_rst = 0;  p_noise = 1; end
        4:       begin maxd = 3; p_to = 0;  p_skip = 30; p_br = 30; p_halt = 20; p_rst = 10; p_noise = 1; end
        default: begin maxd = 9; p_to = 5;  p_skip = 40; p_br = 40; p_halt = 10; p_rst = 5;  p_noise = 1; end
      endcase

      if (cyc >= 2) begin
        exp_en = (m_mode == 1 && m_age == 0) ? (5'b1 << m_stg) : 5'b0;
        chk("stage_en", 32'(stage_en), 32'(exp_en));
        chk("pc",       pc,            m_pc);
        chk("retired",  retired,       m_ret);
        chk("busy",     32'(busy),     32'(m_mode == 1));
        chk("halted",   32'(halted),   32'(m_mode == 2));
        chk("err",      32'(err),      32'(m_mode == 3));
      end

      // Stimulus for the coming edge.
      stuck = (m_mode >= 2) ? stuck + 1 : 0;
      rst   = (cyc < 2) || (int'($urandom_range(0, 999)) < p_rst) || (stuck >= 12);
      start = ($urandom_range(0, 2) == 0);
      stage_done = p_noise != 0 ? 5'($urandom) : 5'b0;
      if (m_mode == 1) begin
        stage_done[m_stg] = (m_age > 0 && m_age == m_d) ||
                            (m_age == 0 && $urandom_range(0, 1) == 1);
      end
      skip_mem      = int'($urandom_range(0, 99)) < p_skip;
      branch_taken  = int'($urandom_range(0, 99)) < p_br;
      branch_target = pick_target();
      halt_req      = int'($urandom_range(0, 99)) < p_halt;

      // Model step for this edge.
      if (rst) begin
        m_mode = 0; m_stg = 0; m_age = 0; m_pc = RPC; m_ret = 0;
      end else if (m_mode == 0) begin
        if (start) begin
          m_mode = 1; m_stg = 0; m_age = 0; m_d = pick_delay(maxd, p_to);
        end
      end else if (m_mode == 1) begin
        if (m_age > 0 && stage_done[m_stg]) begin
          if (m_stg == 4) begin
            if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
            m_pc = branch_taken ? branch_target : m_pc + 1;
            if (halt_req) m_mode = 2;
            else m_stg = 0;
          end else if (m_stg == 2 && skip_mem) begin
            m_stg = 4;
          end else begin
            m_stg = m_stg + 1;
          end
          m_age = 0;
          m_d = pick_delay(maxd, p_to);
        end else if (m_age > 0 && m_age >= TO) begin
          m_mode = 3;
        end else begin
          m_age = m_age + 1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'd0, PC word index loaded at reset.
REQ-002 Parameter: TIMEOUT, 8'd255, maximum wait cycles per stage before error.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  begin execution; sampled only in IDLE.
REQ-006 stage_done  input  5  per-stage completion: [0]fetch [1]decode [2]exec [3]mem [4]writeback.
REQ-007 stage_en  output  5  per-stage one-cycle enable pulse; same bit order as stage_done.
REQ-008 branch_taken  input  1  redirect request; sampled when writeback is done.
REQ-009 branch_target  input  32  next PC (word index) when branch_taken is set.
REQ-010 skip_mem  input  1  instruction has no memory access; sampled when exec is done.
REQ-011 halt_req  input  1  stop after the current instruction; sampled when writeback is done.
REQ-012 pc  output  32  PC word index of the current instruction, driven to the fetch stage.
REQ-013 retired  output  32  count of retired instructions.
REQ-014 busy  output  1  high in states FETCH through WB.
REQ-015 halted  output  1  high in HALT.
REQ-016 err  output  1  high in ERR.

Function
REQ-017 The state machine SHALL have these states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-018 IDLE SHALL move to FETCH when start=1; start SHALL be ignored in every other state.
REQ-019 On the entry cycle of each stage state, the matching stage_en bit SHALL be 1 for exactly one cycle; all other stage_en bits SHALL be 0.
REQ-020 After the entry cycle, the block SHALL wait with stage_en=0 until the matching stage_done bit is 1; done bits seen during the entry cycle, or belonging to another stage, SHALL be ignored.
REQ-021 When a stage's done bit is seen at cycle t, the next state SHALL be entered and its enable pulsed at t+1, giving a minimum of 2 cycles per stage.
REQ-022 Stage order SHALL be FETCH->DECODE->EXEC->MEM->WB, except EXEC->WB when skip_mem=1 at exec done.
REQ-023 At WB done: retired SHALL increment, saturating at 32'hFFFFFFFF.
REQ-024 At WB done: pc SHALL become branch_target if branch_taken=1, otherwise pc+1, with 32-bit wrap (32'hFFFFFFFF+1=0).
REQ-025 At WB done: the next state SHALL be HALT if halt_req=1, otherwise FETCH.
REQ-026 pc SHALL be stable from FETCH entry through WB done.
REQ-027 Watchdog: an 8-bit wait counter SHALL clear on every stage entry and increment each waiting cycle.
REQ-028 If the wait counter reaches TIMEOUT with no done seen, the state SHALL become ERR the next cycle; a done bit arriving in that same cycle SHALL take priority over the timeout.
REQ-029 HALT and ERR SHALL be terminal: stage_en=0, pc and retired frozen, exit only via rst.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set: state=IDLE, stage_en=0, pc=RESET_PC, retired=0, busy=0, halted=0, err=0, wait counter=0.
REQ-031 rst SHALL override any in-flight stage; a partially executed instruction SHALL NOT be counted in retired.

Structure
REQ-032 Package core_pkg SHALL hold the state enum, the stage index constants (STG_FETCH=0 … STG_WB=4) and the stage count (5).
REQ-033 The watchdog SHALL be a sub-module named stage_watchdog (inputs: clear, run; output: expired); the state machine, PC and retired logic stay in core_sequencer.

Verification
REQ-034 Scenario: rst, then start; every done bit returned 1 cycle after its enable -> pulses on bits 0,1,2,3,4 at 2-cycle spacing; retired=1; pc=RESET_PC+1 after 10 cycles.
REQ-035 Scenario: skip_mem=1 at exec done -> no stage_en[3] pulse; WB enable appears the cycle after exec done.
REQ-036 Scenario: branch_taken=1, branch_target=32'd4 at WB done -> next fetch has pc=4; with pc=32'hFFFFFFFF and no branch -> pc=0.
REQ-037 Scenario: TIMEOUT=8, decode_done withheld -> err=1 after 8 waiting cycles; stage_en stays 0 afterwards; a late done does nothing.
REQ-038 Scenario: halt_req=1 at WB done -> halted=1, no further fetch; start pulse ignored; rst returns the block to IDLE with pc=RESET_PC.
REQ-039 Scenario: rst asserted mid-EXEC -> next cycle IDLE, all outputs at reset values, retired unchanged from 0.
